// File: rtl/alu_pkg.sv
// Shared decode definitions: ALU operation codes, RV32I opcodes, and the
// payload that travels from the decoder through the operand buffer.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1111
    } aluctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Compare select for non-branch entries; the ALU compare output is 0 for it.
    localparam logic [2:0] F3_NONBRANCH = 3'b010;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        aluctrl_e    aluctrl;
        logic [2:0]  funct3;
        logic        is_branch;
        logic        illegal;
    } alu_payload_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decode: instruction word plus operands into ALU payload.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic [31:0]  pc,
    input  logic [31:0]  rs1,
    input  logic [31:0]  rs2,
    output alu_payload_t payload
);

    logic [6:0]   opcode;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic [31:0]  imm_i;
    logic [31:0]  imm_s;
    logic [31:0]  imm_u;
    logic         bad;
    alu_payload_t p;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    // Decode by opcode; any illegal form collapses to a zeroed ADD at the end.
    always_comb begin
        p         = '0;
        p.aluctrl = ALU_ADD;
        p.funct3  = F3_NONBRANCH;
        bad       = 1'b0;
        case (opcode)
            OPC_OP: begin
                p.op1 = rs1;
                p.op2 = rs2;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  p.aluctrl = ALU_ADD;
                        3'b001:  p.aluctrl = ALU_SLL;
                        3'b010:  p.aluctrl = ALU_SLT;
                        3'b011:  p.aluctrl = ALU_SLTU;
                        3'b100:  p.aluctrl = ALU_XOR;
                        3'b101:  p.aluctrl = ALU_SRL;
                        3'b110:  p.aluctrl = ALU_OR;
                        default: p.aluctrl = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    p.aluctrl = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    p.aluctrl = ALU_SRA;
                end else begin
                    bad = 1'b1;
                end
                // The ALU shifts by the whole op2, so only the shamt bits may survive.
                if (p.aluctrl == ALU_SLL || p.aluctrl == ALU_SRL || p.aluctrl == ALU_SRA)
                    p.op2 = {27'b0, rs2[4:0]};
            end
            OPC_OP_IMM: begin
                p.op1 = rs1;
                p.op2 = imm_i;
                case (f3)
                    3'b000: p.aluctrl = ALU_ADD;
                    3'b010: p.aluctrl = ALU_SLT;
                    3'b011: p.aluctrl = ALU_SLTU;
                    3'b100: p.aluctrl = ALU_XOR;
                    3'b110: p.aluctrl = ALU_OR;
                    3'b111: p.aluctrl = ALU_AND;
                    3'b001: begin
                        p.aluctrl = ALU_SLL;
                        p.op2     = {27'b0, instr[24:20]};
                        bad       = (f7 != F7_BASE);
                    end
                    default: begin
                        p.aluctrl = instr[30] ? ALU_SRA : ALU_SRL;
                        p.op2     = {27'b0, instr[24:20]};
                        bad       = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                endcase
            end
            OPC_LUI: begin
                p.aluctrl = ALU_PASSB;
                p.op2     = imm_u;
            end
            OPC_AUIPC: begin
                p.op1 = pc;
                p.op2 = imm_u;
            end
            OPC_LOAD: begin
                p.op1 = rs1;
                p.op2 = imm_i;
            end
            OPC_STORE: begin
                p.op1 = rs1;
                p.op2 = imm_s;
            end
            OPC_BRANCH: begin
                p.op1       = rs1;
                p.op2       = rs2;
                p.aluctrl   = ALU_SUB;
                p.funct3    = f3;
                p.is_branch = 1'b1;
                bad         = (f3 == 3'b010) || (f3 == 3'b011);
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            p         = '0;
            p.aluctrl = ALU_ADD;
            p.funct3  = F3_NONBRANCH;
            p.illegal = 1'b1;
        end
        payload = p;
    end

endmodule

// File: rtl/alu_decode_pipe.sv
// Decode stage with a two-entry elastic buffer (output register + skid).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is a register (!skid_valid), so there is no combinational path
// from out_ready back to in_ready. While out_valid && !out_ready the outputs
// hold; an input accepted in that state parks in the skid register, and the
// skid entry always drains before any newer input so order is preserved.
module alu_decode_pipe
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [D_WIDTH-1:0] pc,
    input  logic [D_WIDTH-1:0] rs1_data,
    input  logic [D_WIDTH-1:0] rs2_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] aluop1,
    output logic [D_WIDTH-1:0] aluop2,
    output logic [3:0]         aluctrl,
    output logic [2:0]         funct3,
    output logic               is_branch,
    output logic               illegal
);

    alu_payload_t dec;
    alu_payload_t out_q;
    alu_payload_t skid_q;
    logic         out_v_q;
    logic         skid_v_q;
    logic         accept;
    logic         out_free;

    alu_decoder u_dec (
        .instr   (instr),
        .pc      (pc),
        .rs1     (rs1_data),
        .rs2     (rs2_data),
        .payload (dec)
    );

    assign in_ready = !skid_v_q;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_v_q || out_ready;

    // Buffer control: reset beats flush, flush beats acceptance, skid beats input.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
        end else if (out_free) begin
            if (skid_v_q) begin
                out_q    <= skid_q;
                out_v_q  <= 1'b1;
                skid_v_q <= 1'b0;
            end else begin
                out_v_q <= accept;
                if (accept)
                    out_q <= dec;
            end
        end else if (accept) begin
            skid_q   <= dec;
            skid_v_q <= 1'b1;
        end
    end

    assign out_valid = out_v_q;
    assign aluop1    = out_q.op1;
    assign aluop2    = out_q.op2;
    assign aluctrl   = out_q.aluctrl;
    assign funct3    = out_q.funct3;
    assign is_branch = out_q.is_branch;
    assign illegal   = out_q.illegal;

endmodule
